// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types, used by the timing generator and by the
// renderer for its bounce limits.
package vga_timing_pkg;

  function automatic int span_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_COMPR_SHIFT = 3;

  localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic active;
  } sync_bits_t;

  // Blanked, syncs deasserted: what the delay line holds out of reset.
  localparam sync_bits_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of enable input and timing outputs between the generator and its consumer.
interface vga_timing_gen_if;
  logic       en;
  logic [6:0] compr_hrw;
  logic [6:0] compr_vrw;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_tick;
  logic       frame_tick;
  logic [7:0] frame_cnt;

  modport master (
    input  en,
    output compr_hrw, compr_vrw, hsync, vsync, active, line_tick, frame_tick, frame_cnt
  );

  modport slave (
    output en,
    input  compr_hrw, compr_vrw, hsync, vsync, active, line_tick, frame_tick, frame_cnt
  );
endinterface

// File: rtl/sync_delay_line.sv
// Free-running shift register of configurable width and depth; depth 0 is a wire.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with compressed coordinates, line/frame ticks and
// sync/active outputs delayed to line up with the renderer pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int COMPR_SHIFT = DEF_COMPR_SHIFT,
  parameter int SYNC_DELAY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [6:0] compr_hrw_q, compr_hrw_d;
  logic [6:0] compr_vrw_q, compr_vrw_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  sync_bits_t raw_q, raw_d;
  sync_bits_t sync_out;
  logic       line_wrap;
  logic       frame_wrap;

  // Everything but the ticks holds while en is low; ticks only fire on an enabled wrap.
  always_comb begin
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    frame_cnt_d  = frame_cnt_q;
    compr_hrw_d  = compr_hrw_q;
    compr_vrw_d  = compr_vrw_q;
    raw_d        = raw_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    line_wrap    = (hcnt_q == H_LAST);
    frame_wrap   = line_wrap && (vcnt_q == V_LAST);

    if (bus.en) begin
      hcnt_d = line_wrap ? 10'd0 : hcnt_q + 10'd1;
      if (line_wrap) begin
        vcnt_d = frame_wrap ? 10'd0 : vcnt_q + 10'd1;
      end
      if (frame_wrap) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      line_tick_d   = line_wrap;
      frame_tick_d  = frame_wrap;
      compr_hrw_d   = 7'(hcnt_q >> COMPR_SHIFT);
      compr_vrw_d   = 7'(vcnt_q >> COMPR_SHIFT);
      raw_d.hsync_n = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
      raw_d.vsync_n = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
      raw_d.active  = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      frame_cnt_q  <= '0;
      compr_hrw_q  <= '0;
      compr_vrw_q  <= '0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      raw_q        <= SYNC_IDLE;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      frame_cnt_q  <= frame_cnt_d;
      compr_hrw_q  <= compr_hrw_d;
      compr_vrw_q  <= compr_vrw_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      raw_q        <= raw_d;
    end
  end

  sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   (raw_q),
    .dout  (sync_out)
  );

  assign bus.compr_hrw  = compr_hrw_q;
  assign bus.compr_vrw  = compr_vrw_q;
  assign bus.hsync      = sync_out.hsync_n;
  assign bus.vsync      = sync_out.vsync_n;
  assign bus.active     = sync_out.active;
  assign bus.line_tick  = line_tick_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default-timing instance for line-level behaviour and a
// tiny-raster, zero-delay instance for frame-level behaviour and frame_cnt wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_a ();
  vga_timing_gen_if bus_b ();

  vga_timing_gen #(.SYNC_DELAY(1)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  // 16 x 8 raster: hsync low at hcnt 10..12, vsync low at vcnt 5..6.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COMPR_SHIFT(1), .SYNC_DELAY(0)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  typedef struct {
    int         cycles;
    logic       en;
    logic [6:0] hrw;
    logic [6:0] vrw;
    logic       hs;
    logic       vs;
    logic       act;
    logic       lt;
    logic       ft;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en_val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus_a.en = en_val;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resetA();
    reset_a  = 1'b1;
    bus_a.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0;
  endtask

  task automatic resetB();
    reset_b  = 1'b1;
    bus_b.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b0;
  endtask

  initial begin
    int ticks, tick_cyc, run, max_run, runs, bad, first_tick, period;
    logic [6:0] prev_h, prev_v;
    int ft_cnt, ft_first, fc_first, fc255, fc256, hs_low, vs_low;

    bus_a.en = 1'b0;
    bus_b.en = 1'b0;

    // Cumulative enabled edges after reset; hand-derived for SYNC_DELAY = 1.
    vecs[0]  = '{0,   1'b1, 7'd0,  7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,   1'b1, 7'd0,  7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1,   1'b1, 7'd0,  7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{638, 1'b1, 7'd79, 7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1,   1'b1, 7'd80, 7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1,   1'b1, 7'd80, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{15,  1'b1, 7'd82, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1,   1'b1, 7'd82, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{95,  1'b1, 7'd94, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1,   1'b1, 7'd94, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{46,  1'b1, 7'd99, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1,   1'b1, 7'd0,  7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1,   1'b1, 7'd0,  7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{5,   1'b0, 7'd0,  7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    resetA();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].en, vecs[i].cycles);
      checkOutput($sformatf("vec%0d.compr_hrw", i),  32'(bus_a.compr_hrw),  32'(vecs[i].hrw));
      checkOutput($sformatf("vec%0d.compr_vrw", i),  32'(bus_a.compr_vrw),  32'(vecs[i].vrw));
      checkOutput($sformatf("vec%0d.hsync", i),      32'(bus_a.hsync),      32'(vecs[i].hs));
      checkOutput($sformatf("vec%0d.vsync", i),      32'(bus_a.vsync),      32'(vecs[i].vs));
      checkOutput($sformatf("vec%0d.active", i),     32'(bus_a.active),     32'(vecs[i].act));
      checkOutput($sformatf("vec%0d.line_tick", i),  32'(bus_a.line_tick),  32'(vecs[i].lt));
      checkOutput($sformatf("vec%0d.frame_tick", i), 32'(bus_a.frame_tick), 32'(vecs[i].ft));
    end

    // One full line: single line_tick at cycle 800, one 96-cycle hsync pulse.
    resetA();
    ticks = 0; tick_cyc = 0; run = 0; max_run = 0; runs = 0;
    for (int c = 1; c <= 800; c++) begin
      applyStimulus(1'b1, 1);
      if (bus_a.line_tick) begin
        ticks++;
        tick_cyc = c;
      end
      if (!bus_a.hsync) begin
        if (run == 0) runs++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    checkOutput("line.tick_count", 32'(ticks), 32'd1);
    checkOutput("line.tick_cycle", 32'(tick_cyc), 32'd800);
    checkOutput("line.hsync_low_len", 32'(max_run), 32'd96);
    checkOutput("line.hsync_pulses", 32'(runs), 32'd1);

    // Alternating enable stretches the line to 1600 clocks; compr holds on idle edges.
    resetA();
    ticks = 0; first_tick = 0; period = 0; bad = 0;
    prev_h = bus_a.compr_hrw;
    prev_v = bus_a.compr_vrw;
    for (int c = 1; c <= 3300; c++) begin
      applyStimulus(c[0], 1);
      if (!c[0] && (bus_a.compr_hrw !== prev_h || bus_a.compr_vrw !== prev_v)) bad++;
      prev_h = bus_a.compr_hrw;
      prev_v = bus_a.compr_vrw;
      if (bus_a.line_tick) begin
        ticks++;
        if (ticks == 1) first_tick = c;
        else if (ticks == 2) period = c - first_tick;
      end
    end
    checkOutput("toggle.tick_count", 32'(ticks), 32'd2);
    checkOutput("toggle.first_tick", 32'(first_tick), 32'd1599);
    checkOutput("toggle.period", 32'(period), 32'd1600);
    checkOutput("toggle.compr_hold_errors", 32'(bad), 32'd0);

    // Reset between edges mid-line (hcnt=300, vcnt=1), then a clean restart.
    resetA();
    applyStimulus(1'b1, 1100);
    checkOutput("midreset.pre_hrw", 32'(bus_a.compr_hrw), 32'd37);
    #3;
    reset_a = 1'b1;
    #1;
    checkOutput("midreset.hrw", 32'(bus_a.compr_hrw), 32'd0);
    checkOutput("midreset.vrw", 32'(bus_a.compr_vrw), 32'd0);
    checkOutput("midreset.hsync", 32'(bus_a.hsync), 32'd1);
    checkOutput("midreset.vsync", 32'(bus_a.vsync), 32'd1);
    checkOutput("midreset.active", 32'(bus_a.active), 32'd0);
    checkOutput("midreset.frame_cnt", 32'(bus_a.frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset_a = 1'b0;
    applyStimulus(1'b1, 1);
    checkOutput("restart.hrw", 32'(bus_a.compr_hrw), 32'd0);
    checkOutput("restart.vrw", 32'(bus_a.compr_vrw), 32'd0);
    applyStimulus(1'b1, 798);
    checkOutput("restart.tick_799", 32'(bus_a.line_tick), 32'd0);
    applyStimulus(1'b1, 1);
    checkOutput("restart.tick_800", 32'(bus_a.line_tick), 32'd1);
    bus_a.en = 1'b0;

    // Small raster: 128-clock frames, 256 of them to see frame_cnt wrap.
    resetB();
    checkOutput("b.reset_hsync", 32'(bus_b.hsync), 32'd1);
    checkOutput("b.reset_vsync", 32'(bus_b.vsync), 32'd1);
    checkOutput("b.reset_active", 32'(bus_b.active), 32'd0);
    checkOutput("b.reset_frame_cnt", 32'(bus_b.frame_cnt), 32'd0);
    ft_cnt = 0; ft_first = 0; fc_first = -1; fc255 = -1; fc256 = -1; hs_low = 0; vs_low = 0; bad = 0;
    for (int c = 1; c <= 32768; c++) begin
      bus_b.en = 1'b1;
      @(posedge clk);
      #1;
      if (c == 1) checkOutput("b.depth0_active", 32'(bus_b.active), 32'd1);
      if (c <= 16 && !bus_b.hsync) hs_low++;
      if (c <= 128 && !bus_b.vsync) vs_low++;
      if (bus_b.frame_tick) begin
        ft_cnt++;
        if (!bus_b.line_tick) bad++;
        if (ft_cnt == 1) begin
          ft_first = c;
          fc_first = int'(bus_b.frame_cnt);
        end
        if (ft_cnt == 255) fc255 = int'(bus_b.frame_cnt);
        if (ft_cnt == 256) fc256 = int'(bus_b.frame_cnt);
      end
    end
    bus_b.en = 1'b0;
    checkOutput("b.hsync_low_line", 32'(hs_low), 32'd3);
    checkOutput("b.vsync_low_frame", 32'(vs_low), 32'd32);
    checkOutput("b.frame_ticks", 32'(ft_cnt), 32'd256);
    checkOutput("b.first_frame_tick", 32'(ft_first), 32'd128);
    checkOutput("b.frame_cnt_first", 32'(fc_first), 32'd1);
    checkOutput("b.frame_cnt_255", 32'(fc255), 32'd255);
    checkOutput("b.frame_cnt_wrap", 32'(fc256), 32'd0);
    checkOutput("b.frame_tick_without_line_tick", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
